// File: rtl/me_block_sequencer.sv
// me_block_sequencer
// Frame-level control for the motion estimator core. It walks the macroblocks
// of a frame in raster order. For each block it starts a search and waits for
// the core to finish, or for the watchdog to give up. The result is tagged
// with the block coordinates and queued in a first-word-fall-through FIFO that
// downstream consumers drain through a valid/ready handshake.
//
// Ports
//   clk, rst            rising-edge clock, async active-high reset
//   frame_start         one-cycle request to process a frame (accepted in IDLE only)
//   frame_busy          high from frame accept until frame_done
//   frame_done          one-cycle pulse after the last block's result is queued
//   me_start            core start_signal, high for the whole search
//   me_completed        core process_completed level; its rising edge ends a search
//   me_best_dist        core best_distance
//   me_mv_x, me_mv_y    core motion vector (two's complement)
//   block_x, block_y    coordinates of the current block
//   res_valid           FIFO head valid
//   res_ready           consumer accepts the head
//   res_data            {block_y, block_x, timeout, best_dist, mv_y, mv_x}
//   timeout_err         sticky: a block in the current/last frame timed out
module me_block_sequencer #(
  parameter int BLOCKS_X    = 4,
  parameter int BLOCKS_Y    = 4,
  parameter int DIST_W      = 8,
  parameter int MV_W        = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 4095,
  localparam int BXW   = (BLOCKS_X > 1) ? $clog2(BLOCKS_X) : 1,
  localparam int BYW   = (BLOCKS_Y > 1) ? $clog2(BLOCKS_Y) : 1,
  localparam int RES_W = BYW + BXW + 1 + DIST_W + 2 * MV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              me_start,
  input  logic              me_completed,
  input  logic [DIST_W-1:0] me_best_dist,
  input  logic [MV_W-1:0]   me_mv_x,
  input  logic [MV_W-1:0]   me_mv_y,
  output logic [BXW-1:0]    block_x,
  output logic [BYW-1:0]    block_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              timeout_err
);

  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BXW-1:0] X_LAST   = BXW'(BLOCKS_X - 1);
  localparam logic [BYW-1:0] Y_LAST   = BYW'(BLOCKS_Y - 1);
  localparam logic [PW-1:0]  PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RUN, S_CAPTURE, S_GAP, S_NEXT, S_DONE
  } state_t;

  state_t state_q, state_d;

  // Search bookkeeping
  logic              comp_q;       // me_completed from the previous cycle
  logic [WDW-1:0]    wd_q;         // RUN cycles spent on the current block
  logic              hold_timeout;
  logic [DIST_W-1:0] hold_dist;
  logic [MV_W-1:0]   hold_mv_x;
  logic [MV_W-1:0]   hold_mv_y;

  // Result FIFO
  logic [RES_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    fifo_count;
  logic             push, pop, fifo_full;

  logic comp_edge, wd_expired, last_block;

  // A level that was already high when RUN began is not an edge, because
  // comp_q tracks the input in every state.
  assign comp_edge  = me_completed && !comp_q;
  // This is the TIMEOUT_CYC-th RUN cycle.
  assign wd_expired = (wd_q == WD_LAST);
  assign last_block = (block_x == X_LAST) && (block_y == Y_LAST);
  assign fifo_full  = (fifo_count == DEPTH_C);

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, whatever the order of the statements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (frame_start) state_d = S_ARM;
      // Only start a search whose result has room in the FIFO.
      S_ARM:     if (!fifo_full) state_d = S_RUN;
      S_RUN:     if (comp_edge || wd_expired) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_GAP;
      // Let the core drop process_completed before the next search.
      S_GAP:     if (!me_completed) state_d = S_NEXT;
      S_NEXT:    state_d = last_block ? S_DONE : S_ARM;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    me_start   = (state_q == S_RUN);
    frame_busy = (state_q != S_IDLE);
    frame_done = (state_q == S_DONE);
    push       = (state_q == S_CAPTURE);
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_q       <= 1'b0;
      wd_q         <= '0;
      hold_timeout <= 1'b0;
      hold_dist    <= '0;
      hold_mv_x    <= '0;
      hold_mv_y    <= '0;
      block_x      <= '0;
      block_y      <= '0;
      timeout_err  <= 1'b0;
    end else begin
      comp_q <= me_completed;
      wd_q   <= (state_q == S_RUN) ? wd_q + 1'b1 : '0;

      if (state_q == S_RUN) begin
        // If the edge and the timeout land on the same cycle, the edge wins.
        if (comp_edge) begin
          hold_timeout <= 1'b0;
          hold_dist    <= me_best_dist;
          hold_mv_x    <= me_mv_x;
          hold_mv_y    <= me_mv_y;
        end else if (wd_expired) begin
          hold_timeout <= 1'b1;
          hold_dist    <= '1;
          hold_mv_x    <= '0;
          hold_mv_y    <= '0;
          timeout_err  <= 1'b1;
        end
      end

      if (state_q == S_IDLE) begin
        block_x <= '0;
        block_y <= '0;
        if (frame_start) timeout_err <= 1'b0;
      end else if (state_q == S_NEXT && !last_block) begin
        if (block_x == X_LAST) begin
          block_x <= '0;
          block_y <= block_y + 1'b1;
        end else begin
          block_x <= block_x + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------- FIFO
  assign res_valid = (fifo_count != '0);
  assign pop       = res_valid && res_ready;
  // Gate the head so the output reads zero while the FIFO is empty.
  assign res_data  = res_valid ? mem[rd_ptr] : '0;

  // NOTE: the storage array has no reset. Only the pointers and the count
  // define which entries are valid, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {block_y, block_x, hold_timeout, hold_dist, hold_mv_y, hold_mv_x};
  end

  // The ARM guard ensures that push never occurs while the FIFO is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

endmodule
